period_stats_acq: RTL and testbench
===================================

Name: period_stats_acq

Overview:
- Receiver-side companion to the on-chip test-waveform generator.
- Captures the 8-bit sample stream plus its period marker, both paced by the slow sample clock.
- Measures each waveform period: minimum, maximum, sum of samples and sample count.
- Publishes one result set per completed period to the acquisition/readout logic with a single-cycle valid strobe.

Parameters:
DATA_W, 8, sample width in bits
MAX_SAMPLES, 256, largest legal period length in samples
CNT_W, 9, sample-count width; must hold MAX_SAMPLES
SUM_W, 16, accumulator width; must be at least DATA_W + log2(MAX_SAMPLES)

Ports:
clk  in  1  system clock; every register is in this domain
rst  in  1  asynchronous, active-high reset
enable  in  1  acquisition enable, sampled on clk
sample_clk  in  1  slow sample clock, asynchronous to clk; a sample is taken on its rising edge
sample_in  in  DATA_W  sample value; stable for at least 4 clk after each sample_clk rise
new_period  in  1  high while the current sample is the first sample of a period
per_min  out  DATA_W  minimum sample of the last completed period
per_max  out  DATA_W  maximum sample of the last completed period
per_sum  out  SUM_W  sum of the samples of the last completed period
per_cnt  out  CNT_W  number of samples in the last completed period
per_valid  out  1  one-clk pulse; result outputs updated this cycle
overflow  out  1  sticky flag: a period exceeded MAX_SAMPLES
busy  out  1  high in state ACQ

Behaviour:
- Reset (async, rst=1):
  - all outputs 0; state IDLE.
  - Internal min/max/sum/cnt and both sync flops are 0.
- Edge detect:
  - sample_clk passes through a 2-flop synchronizer, then a third flop.
  - "take" is high for exactly one clk when sync2=1 and sync3=0.
  - "take" therefore occurs on the 3rd clk edge after sample_clk rises. sample_in and new_period are read only in that cycle.
- State IDLE:
  - If take && enable && new_period: go to ACQ and seed min=max=sum=sample_in, cnt=1.
  - take with new_period=0 is ignored. This is the mid-period start: wait for the first period marker.
- State ACQ, on take with new_period=0:
  - If cnt==MAX_SAMPLES: set overflow=1, go to IDLE, discard partial data, no per_valid.
  - Otherwise: cnt+=1, sum+=sample_in (zero-extended), and update min/max when sample_in is strictly less / strictly greater.
- State ACQ, on take with new_period=1 (period close):
  - On the same clk edge, load per_min/per_max/per_sum/per_cnt from the internal values before this sample.
  - Assert per_valid for that one cycle.
  - Re-seed the internal registers with the current sample, cnt=1, and stay in ACQ.
- Disabling:
  - enable=0 in any state: next clk go to IDLE and drop partial accumulation.
  - Result outputs hold their last values; overflow clears.
  - If enable=0 in the same cycle as take, enable wins: the sample is not taken and no per_valid is produced.
- Overflow:
  - overflow stays 1 until rst or enable=0.
  - While overflow=1, acquisition still resumes at the next new_period; only the flag is sticky.
- Arithmetic and outputs:
  - No saturation is needed: SUM_W is sized for MAX_SAMPLES full-scale samples.
  - Result outputs change only on a per_valid cycle or on reset.
  - busy = (state==ACQ).
- Latency: per_valid occurs 3 clk after the sample_clk rise that carries the next period's new_period.
- Mid-operation reset: clears everything immediately; no per_valid is emitted.

Test Plan:
- Ramp and sum: enable=1; feed samples 0..255 with new_period only on sample 0, then one more new_period sample -> per_valid once; per_min=0, per_max=255, per_sum=32640, per_cnt=256, overflow=0.
- Constant level: 100 samples of 128 bracketed by two new_period markers -> per_min=per_max=128, per_sum=12800, per_cnt=100.
- Mid-period start: start the stream at sample 37 of a 64-sample period -> no per_valid until two markers have been taken; first result has per_cnt=64.
- Overflow: one marker followed by 256 non-marker samples -> overflow=1 on the 257th take, busy=0, no per_valid; next marker restarts with busy=1 and overflow still 1.
- Enable conflict: drop enable in the exact cycle take fires with new_period=1 -> no per_valid, state IDLE, outputs unchanged, overflow=0.
- Reset mid-period: assert rst halfway through a period -> all outputs 0 immediately; after release, the first per_valid comes only after two further markers.

Source files
------------

// File: rtl/period_stats_acq.sv
// Per-period statistics capture for the test-waveform sample stream.
// Publishes min/max/sum/count of each completed period with a one-cycle valid strobe.
module period_stats_acq #(
    parameter int DATA_W      = 8,
    parameter int MAX_SAMPLES = 256,
    parameter int CNT_W       = 9,
    parameter int SUM_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_clk,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              new_period,
    output logic [DATA_W-1:0] per_min,
    output logic [DATA_W-1:0] per_max,
    output logic [SUM_W-1:0]  per_sum,
    output logic [CNT_W-1:0]  per_cnt,
    output logic              per_valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } state_t;

    state_t            state_q;
    logic              sync1_q, sync2_q, sync3_q;
    logic [DATA_W-1:0] min_q, max_q;
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] per_min_q, per_max_q;
    logic [SUM_W-1:0]  per_sum_q;
    logic [CNT_W-1:0]  per_cnt_q;
    logic              per_valid_q;
    logic              overflow_q;

    logic              take_d;
    logic              full_d;
    logic [SUM_W-1:0]  sample_ext_d;

    // One-clk strobe on the synchronized rising edge of the slow sample clock.
    assign take_d       = sync2_q & ~sync3_q;
    assign full_d       = (cnt_q == CNT_W'(MAX_SAMPLES));
    assign sample_ext_d = SUM_W'(sample_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            per_min_q   <= '0;
            per_max_q   <= '0;
            per_sum_q   <= '0;
            per_cnt_q   <= '0;
            per_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sample_clk;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            per_valid_q <= 1'b0;

            if (!enable) begin
                // Disable has priority over a coincident take and drops any partial period.
                state_q    <= IDLE;
                overflow_q <= 1'b0;
                min_q      <= '0;
                max_q      <= '0;
                sum_q      <= '0;
                cnt_q      <= '0;
            end else if (take_d) begin
                unique case (state_q)
                    IDLE: begin
                        if (new_period) begin
                            state_q <= ACQ;
                            min_q   <= sample_in;
                            max_q   <= sample_in;
                            sum_q   <= sample_ext_d;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ACQ: begin
                        if (new_period) begin
                            per_min_q   <= min_q;
                            per_max_q   <= max_q;
                            per_sum_q   <= sum_q;
                            per_cnt_q   <= cnt_q;
                            per_valid_q <= 1'b1;
                            min_q       <= sample_in;
                            max_q       <= sample_in;
                            sum_q       <= sample_ext_d;
                            cnt_q       <= CNT_W'(1);
                        end else if (full_d) begin
                            overflow_q <= 1'b1;
                            state_q    <= IDLE;
                            min_q      <= '0;
                            max_q      <= '0;
                            sum_q      <= '0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            sum_q <= sum_q + sample_ext_d;
                            if (sample_in < min_q) min_q <= sample_in;
                            if (sample_in > max_q) max_q <= sample_in;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign per_min   = per_min_q;
    assign per_max   = per_max_q;
    assign per_sum   = per_sum_q;
    assign per_cnt   = per_cnt_q;
    assign per_valid = per_valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == ACQ);

endmodule

// File: tb/tb_period_stats_acq.sv
// Directed and randomized bench for period_stats_acq against a sample-list reference model.
module tb_period_stats_acq;

    localparam int DATA_W      = 8;
    localparam int MAX_SAMPLES = 256;
    localparam int CNT_W       = 9;
    localparam int SUM_W       = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              sample_clk;
    logic [DATA_W-1:0] sample_in;
    logic              new_period;
    logic [DATA_W-1:0] per_min;
    logic [DATA_W-1:0] per_max;
    logic [SUM_W-1:0]  per_sum;
    logic [CNT_W-1:0]  per_cnt;
    logic              per_valid;
    logic              overflow;
    logic              busy;

    period_stats_acq #(
        .DATA_W(DATA_W), .MAX_SAMPLES(MAX_SAMPLES), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_clk(sample_clk),
        .sample_in(sample_in), .new_period(new_period),
        .per_min(per_min), .per_max(per_max), .per_sum(per_sum), .per_cnt(per_cnt),
        .per_valid(per_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the samples of the period in progress plus the last published results.
    int cur[$];
    bit m_acq = 1'b0;
    bit m_ovf = 1'b0;
    int e_min = 0, e_max = 0, e_sum = 0, e_cnt = 0;
    int nv, lat;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_min"}, int'(per_min), e_min);
        chk({tag, "_max"}, int'(per_max), e_max);
        chk({tag, "_sum"}, int'(per_sum), e_sum);
        chk({tag, "_cnt"}, int'(per_cnt), e_cnt);
        chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, "_busy"}, int'(busy), int'(m_acq));
    endtask

    function automatic void publish();
        e_min = 255; e_max = 0; e_sum = 0;
        foreach (cur[k]) begin
            if (cur[k] < e_min) e_min = cur[k];
            if (cur[k] > e_max) e_max = cur[k];
            e_sum += cur[k];
        end
        e_cnt = cur.size();
    endfunction

    // One sample_clk pulse carrying (v, np); conflict drops enable exactly on the take cycle.
    task automatic send(input int v, input bit np, input bit conflict);
        int hi = $urandom_range(5, 8);
        int lo = $urandom_range(3, 6);
        bit exp_v = 1'b0;
        @(negedge clk);
        sample_in  = 8'(v);
        new_period = np;
        sample_clk = 1'b1;
        nv = 0; lat = 0;
        for (int i = 1; i <= hi + lo; i++) begin
            @(negedge clk);
            if (conflict && i == 2) enable = 1'b0;
            if (conflict && i == 3) enable = 1'b1;
            if (per_valid) begin
                nv++;
                if (lat == 0) lat = i;
            end
            if (i == hi) sample_clk = 1'b0;
        end
        if (conflict) begin
            m_acq = 1'b0; m_ovf = 1'b0; cur.delete();
        end else if (!m_acq) begin
            if (np) begin m_acq = 1'b1; cur.delete(); cur.push_back(v); end
        end else if (np) begin
            exp_v = 1'b1; publish(); cur.delete(); cur.push_back(v);
        end else if (cur.size() == MAX_SAMPLES) begin
            m_ovf = 1'b1; m_acq = 1'b0; cur.delete();
        end else begin
            cur.push_back(v);
        end
        chk("valid_count", nv, int'(exp_v));
        if (exp_v) chk("valid_latency", lat, 3);
        check_state("post_sample");
    endtask

    task automatic rnd_period(input int len);
        send($urandom_range(0, 255), 1'b1, 1'b0);
        for (int i = 1; i < len; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
    endtask

    task automatic drop_enable(input int n);
        @(negedge clk);
        enable = 1'b0;
        repeat (n) @(negedge clk);
        m_acq = 1'b0; m_ovf = 1'b0; cur.delete();
        check_state("disabled");
        enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; sample_clk = 1'b0; sample_in = '0; new_period = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_valid", int'(per_valid), 0);
        rst = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp 0..255 closed by the next marker.
        for (int v = 0; v < 256; v++) send(v, v == 0, 1'b0);
        send(7, 1'b1, 1'b0);
        chk("ramp_min", int'(per_min), 0);
        chk("ramp_max", int'(per_max), 255);
        chk("ramp_sum", int'(per_sum), 32640);
        chk("ramp_cnt", int'(per_cnt), 256);
        chk("ramp_overflow", int'(overflow), 0);

        // Constant level of 100 samples.
        send(128, 1'b1, 1'b0);
        for (int i = 1; i < 100; i++) send(128, 1'b0, 1'b0);
        send(9, 1'b1, 1'b0);
        chk("const_min", int'(per_min), 128);
        chk("const_max", int'(per_max), 128);
        chk("const_sum", int'(per_sum), 12800);
        chk("const_cnt", int'(per_cnt), 100);

        // Mid-period start at sample 37 of a 64-sample period.
        drop_enable(4);
        for (int i = 37; i < 64; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
        rnd_period(64);
        send($urandom_range(0, 255), 1'b1, 1'b0);
        chk("midstart_cnt", int'(per_cnt), 64);

        // Overflow: marker then 256 non-marker samples.
        for (int i = 0; i < 256; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_busy", int'(busy), 0);
        send($urandom_range(0, 255), 1'b1, 1'b0);
        chk("ovf_restart_busy", int'(busy), 1);
        chk("ovf_restart_flag", int'(overflow), 1);
        for (int i = 0; i < 5; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
        send($urandom_range(0, 255), 1'b1, 1'b0);
        chk("ovf_next_cnt", int'(per_cnt), 6);

        // Enable dropped in the exact take cycle of a marker.
        for (int i = 0; i < 4; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
        send($urandom_range(0, 255), 1'b1, 1'b1);
        chk("conflict_valid", nv, 0);
        chk("conflict_busy", int'(busy), 0);
        chk("conflict_overflow", int'(overflow), 0);

        // Random periods of varied length.
        for (int p = 0; p < 8; p++) rnd_period($urandom_range(1, 20));
        send($urandom_range(0, 255), 1'b1, 1'b0);

        // Reset in the middle of a period.
        for (int i = 0; i < 10; i++) send($urandom_range(0, 255), 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_acq = 1'b0; m_ovf = 1'b0; cur.delete();
        e_min = 0; e_max = 0; e_sum = 0; e_cnt = 0;
        check_state("midreset");
        chk("midreset_valid", int'(per_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        rnd_period(6);
        send($urandom_range(0, 255), 1'b1, 1'b0);
        chk("postreset_cnt", int'(per_cnt), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
